// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the multiply functional unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int MUL_DW = 32;
  localparam int DW     = MUL_DW;
  localparam int PW     = 2 * DW;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] MUL_FUNCT  = 6'b011000;

  typedef struct packed {
    logic          valid;
    logic [4:0]    regdest;
    logic          writereg;
    logic          writeov;
    logic [PW-1:0] product;
  } mul_stage_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_stage_reg
//  Description : One multiply pipeline stage register, enabled by advance,
//                asynchronously cleared by an active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_stage_reg
  import mul_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  mul_stage_t d_i,
  output mul_stage_t q_o
);

  mul_stage_t stage_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule : mul_stage_reg
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_unit
//  Description : Fixed-latency multiply unit with valid/grant writeback and
//                architectural HI/LO. Optional overflow trap: MUL_OVERFLOW_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_unit
  import mul_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DW      = mul_pkg::MUL_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iss_mul_oper,
  input  logic [DW-1:0] iss_ex_rega,
  input  logic [DW-1:0] iss_ex_regb,
  input  logic          iss_ex_unsig,
  input  logic [4:0]    iss_ex_regdest,
  input  logic          iss_ex_writereg,
  input  logic          iss_ex_writeov,
  output logic          mul_ready,
  output logic          mul_wb_valid,
  output logic [4:0]    mul_wb_regdest,
  output logic          mul_wb_writereg,
  output logic [DW-1:0] mul_wb_data,
  output logic          mul_wb_ov,
  input  logic          wb_mul_grant,
  output logic [DW-1:0] mul_hi,
  output logic [DW-1:0] mul_lo,
  output logic          mul_idle,
  output logic          mul_err
);

  localparam int CW = $clog2(LATENCY + 1);

  generate
    if (DW != MUL_DW) begin : g_dw_check
      $error("mul_unit: DW must match mul_pkg::MUL_DW");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_lat_check
      $error("mul_unit: LATENCY must be within 1..8");
    end
  endgenerate

  mul_stage_t      stage_d [LATENCY];
  mul_stage_t      stage_q [LATENCY];
  mul_stage_t      stage0_d;
  mul_stage_t      last_q;

  logic            advance;
  logic            accept;
  logic            complete;
  logic [PW-1:0]   ext_a;
  logic [PW-1:0]   ext_b;
  logic [PW-1:0]   product;
  logic            ov_event;

  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;

  assign last_q   = stage_q[LATENCY-1];
  assign advance  = !last_q.valid || wb_mul_grant;
  assign accept   = iss_mul_oper && advance;
  assign complete = last_q.valid && wb_mul_grant;

  // Truncating a 2*DW multiply of extended operands gives the exact product
  // for both signed and unsigned interpretations.
  assign ext_a   = iss_ex_unsig ? {{DW{1'b0}}, iss_ex_rega}
                                : {{DW{iss_ex_rega[DW-1]}}, iss_ex_rega};
  assign ext_b   = iss_ex_unsig ? {{DW{1'b0}}, iss_ex_regb}
                                : {{DW{iss_ex_regb[DW-1]}}, iss_ex_regb};
  assign product = ext_a * ext_b;

`ifdef MUL_OVERFLOW_EN
  always_comb begin
    ov_event = 1'b0;
    if (iss_ex_unsig) begin
      ov_event = |product[PW-1:DW];
    end else begin
      ov_event = !((&product[PW-1:DW-1]) || !(|product[PW-1:DW-1]));
    end
  end
`else
  assign ov_event = 1'b0;
`endif

  // writeov is resolved at stage 0 into "trap taken", since signedness is
  // not carried down the pipeline.
  always_comb begin
    stage0_d = '0;
    if (accept) begin
      stage0_d.valid    = 1'b1;
      stage0_d.regdest  = iss_ex_regdest;
      stage0_d.writereg = iss_ex_writereg;
      stage0_d.writeov  = iss_ex_writeov && ov_event;
      stage0_d.product  = product;
    end
  end

  generate
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      if (i == 0) begin : g_first
        assign stage_d[i] = stage0_d;
      end else begin : g_next
        assign stage_d[i] = stage_q[i-1];
      end

      mul_stage_reg u_stage (
        .clock (clock),
        .reset (reset),
        .en_i  (advance),
        .d_i   (stage_d[i]),
        .q_o   (stage_q[i])
      );
    end
  endgenerate

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    err_d   = err_q;
    if (complete) begin
      hi_d = last_q.product[PW-1:DW];
      lo_d = last_q.product[DW-1:0];
    end
    if (accept && !complete) begin
      count_d = count_q + CW'(1);
    end else if (complete && !accept) begin
      count_d = count_q - CW'(1);
    end
    if (iss_mul_oper && !advance) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign mul_ready       = advance;
  assign mul_wb_valid    = last_q.valid;
  assign mul_wb_regdest  = last_q.regdest;
  assign mul_wb_ov       = last_q.writeov;
  assign mul_wb_writereg = last_q.writereg && !last_q.writeov;
  assign mul_wb_data     = last_q.product[DW-1:0];
  assign mul_hi          = hi_q;
  assign mul_lo          = lo_q;
  assign mul_idle        = (count_q == '0);
  assign mul_err         = err_q;

endmodule : mul_unit
`default_nettype wire

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multiply functional unit of the execution stage, directly downstream of the issue stage.
- Accepts an operation when the issue stage asserts its multiply-unit select, which the issue stage decodes for op 000000 / funct 011000.
- Computes a 64-bit product in a fixed-latency pipeline and presents the result to writeback through a valid/grant handshake.
- Holds the architectural HI/LO pair.

Parameters:
- LATENCY, 3, pipeline depth in cycles from accept to mul_wb_valid (legal 1..8).
- DW, 32, operand width.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- iss_mul_oper  input  1  issue selects this unit this cycle
- iss_ex_rega  input  DW  operand A
- iss_ex_regb  input  DW  operand B
- iss_ex_unsig  input  1  1 = unsigned multiply, 0 = signed
- iss_ex_regdest  input  5  destination register for LO result
- iss_ex_writereg  input  1  destination write enable
- iss_ex_writeov  input  1  overflow trap requested
- mul_ready  output  1  unit can accept this cycle
- mul_wb_valid  output  1  result in output stage
- mul_wb_regdest  output  5  destination of output-stage result
- mul_wb_writereg  output  1  write enable of output-stage result
- mul_wb_data  output  DW  low word of product
- mul_wb_ov  output  1  overflow flag (0 when MUL_OVERFLOW_EN undefined)
- wb_mul_grant  input  1  writeback consumes output stage this cycle
- mul_hi  output  DW  architectural HI register
- mul_lo  output  DW  architectural LO register
- mul_idle  output  1  no operation in flight
- mul_err  output  1  sticky protocol error

Behaviour:
- Reset (async, reset=0): all stage valid bits 0; mul_hi = mul_lo = 0; mul_wb_* outputs 0; mul_err = 0; in-flight counter 0.
- Reset mid-operation discards all in-flight results; no writeback occurs for them.
- Pipeline structure: LATENCY stages, each holding valid, regdest, writereg, writeov, 64-bit product.
  - Stage 0 loads on accept.
  - Product is formed at stage 0 from operands extended to 2*DW bits: sign-extended when iss_ex_unsig=0, zero-extended when 1.
  - Later stages only shift the product along.
- Advance: advance = !out_valid || wb_mul_grant.
  - The whole pipeline moves together when advance=1 and holds entirely when advance=0.
- mul_ready = advance, combinational.
- Accept: when iss_mul_oper && mul_ready, stage 0 captures the operation; otherwise stage 0 loads valid=0 on advance.
- Throughput: 1 operation per cycle. Latency: exactly LATENCY cycles from accept edge to mul_wb_valid, absent backpressure.
- Output stage: mul_wb_valid, mul_wb_regdest, mul_wb_writereg and mul_wb_data (product[DW-1:0]) are driven directly from last-stage registers.
- Completion: on a cycle with mul_wb_valid && wb_mul_grant:
  - mul_hi <= product[2DW-1:DW];
  - mul_lo <= product[DW-1:0].
- wb_mul_grant while mul_wb_valid=0 is ignored; no HI/LO update.
- In-flight counter:
  - +1 on accept, −1 on completion, unchanged when both occur together.
  - Range 0..LATENCY.
  - mul_idle = (count == 0).
- Full with grant: accept and completion in the same cycle are legal; the pipeline stays full.
- Full without grant: mul_ready=0.
  - If iss_mul_oper=1 in that cycle, the operation is dropped and mul_err is set (sticky until reset).
  - The issue stage must not present operations while mul_ready=0.
- A result with writereg=0 still completes and still updates HI/LO.

Optional Feature:
- Macro MUL_OVERFLOW_EN.
- Defined: mul_wb_ov = last-stage writeov && (product does not fit in DW bits).
  - Signed: upper DW+1 bits are not all equal.
  - Unsigned: upper DW bits are nonzero.
- When mul_wb_ov=1, mul_wb_writereg is forced 0; HI/LO still update on grant.
- Undefined: mul_wb_ov tied 0; writeov is not stored in the pipeline.

Decomposition:
- Shared package (mul_pkg) holds:
  - stage-record typedef {valid, regdest, writereg, writeov, product};
  - constants MUL_FUNCT = 6'b011000 and OP_SPECIAL = 6'b000000;
  - localparam PW = 2*DW.
- One sub-module, mul_stage_reg: a single pipeline register with an enable (advance) and an async clear.
  - mul_unit instantiates it LATENCY times.

Test Plan:
1. Reset, then a signed multiply, A=0xFFFFFFFE (−2), B=3, regdest=5, grant held 1 -> after 3 cycles mul_wb_valid=1, data=0xFFFFFFFA, regdest=5; next cycle mul_hi=0xFFFFFFFF, mul_lo=0xFFFFFFFA.
2. The same operands with unsig=1 -> data=0xFFFFFFFA, mul_hi=0x00000002.
3. Four back-to-back operations (1×1, 2×2, 3×3, 4×4) with grant=1 -> results 1, 4, 9, 16 on consecutive cycles 3–6; mul_idle=1 after the last completion.
4. Fill the pipeline (3 operations), then grant=0 for 5 cycles -> mul_ready=0 and the outputs hold their first result. Present iss_mul_oper=1 while full -> mul_err=1. Release grant -> the 3 results drain in order.
5. Assert reset with 2 operations in flight -> mul_wb_valid=0, mul_hi=mul_lo=0, mul_idle=1, and no later writeback appears.
6. With MUL_OVERFLOW_EN: signed A=0x00010000, B=0x00010000, writeov=1, writereg=1 -> mul_wb_ov=1, mul_wb_writereg=0, mul_hi=0x00000001 after grant.
